// File: rtl/drum_accumulator.sv
// Saturating frame accumulator behind the approximate multiplier.
// Sums unsigned products per frame, then holds sum/count/saturation for readout.
module drum_accumulator #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 16,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_product,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_sat
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   // Count value whose increment reaches the maximum frame length.
   localparam logic [CNT_W-1:0] CNT_PRE_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;

   logic             accept;
   logic [ACC_W:0]   sum_ext;

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = acc_q;
   assign out_count = count_q;
   assign out_sat   = sat_q;

   assign accept  = in_ready & in_valid;
   assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      sat_d   = sat_q;

      if (clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         count_d = '0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  acc_d   = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
                  sat_d   = sat_q | sum_ext[ACC_W];
                  count_d = count_q + 1'b1;
                  if (in_last || (count_q == CNT_PRE_MAX)) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  count_d = '0;
                  sat_d   = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

endmodule
